// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b, one bit per clock, LSB
//   first, built around a single full-subtractor cell with a registered
//   borrow. Operands arrive over a valid/ready handshake; the result leaves
//   over another valid/ready handshake.
//
//   Optional feature macro: SERSUB_OVF_EN adds the ovf output (signed
//   overflow of the two's-complement subtraction).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block idle, can accept operands
//   a, b       minuend / subtrahend (WIDTH bits)
//   out_valid  diff/bout (and ovf) hold a finished result
//   out_ready  sink accepts the result
//   diff       a - b mod 2^WIDTH
//   bout       final borrow, 1 iff a < b unsigned
//   ovf        signed overflow (SERSUB_OVF_EN only)

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  logic d_bit;
  logic b_cell;

`ifdef SERSUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  always_comb begin
    d_bit  = a_sr[0] ^ b_sr[0] ^ borrow;
    b_cell = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      bout    <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
`ifdef SERSUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          borrow  <= b_cell;
          if (cnt == CNT_LAST) begin
            // Last bit: d_bit is the result MSB, b_cell the final borrow.
            state <= DONE;
            bout  <= b_cell;
`ifdef SERSUB_OVF_EN
            ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_sr;

endmodule
